// File: rtl/sd_pkg.sv
// Shared definitions for the SPI-mode SD card response path: response type
// encodings, response lengths, receiver FSM states and the timeout response.
package sd_pkg;

  // response_type encodings driven by the controller FSM (3 is treated as R1)
  localparam logic [1:0] SdRespR1   = 2'd0;
  localparam logic [1:0] SdRespR1b  = 2'd1;
  localparam logic [1:0] SdRespR3R7 = 2'd2;

  // Response lengths in bits, counting the start bit
  localparam logic [5:0] SdLenShort = 6'd8;
  localparam logic [5:0] SdLenLong  = 6'd40;

  // Value reported when no start bit arrives inside the N_CR window
  localparam logic [39:0] SdTimeoutResp = 40'hFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    SdIdle      = 3'd0,
    SdWaitStart = 3'd1,
    SdShift     = 3'd2,
    SdWaitBusy  = 3'd3,
    SdDone      = 3'd4
  } sd_rx_state_e;

  // Number of bits to collect for the latched response kind
  function automatic logic [5:0] sd_resp_len(input logic is_long);
    return is_long ? SdLenLong : SdLenShort;
  endfunction

endpackage

// File: rtl/sd_resp_receiver.sv
// SPI-mode SD response receiver: hunts MISO for the start bit within N_CR,
// shifts in an R1 / R1b / R3-R7 response MSB-first, waits out R1b busy and
// reports completion with a one-cycle valid strobe (optionally a timeout).
module sd_resp_receiver
  import sd_pkg::*;
#(
  parameter int NCR_MAX_SAMPLES  = 80,
  parameter int BUSY_MAX_SAMPLES = 500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        miso,
  input  logic        sample_en,
  input  logic        receive,
  input  logic [1:0]  response_type,
  output logic [39:0] response,
  output logic        response_valid,
  output logic        timeout,
  output logic        busy
);

  // Both limits live in the 24-bit sample counter domain
  localparam logic [23:0] NcrLimit  = 24'(NCR_MAX_SAMPLES);
  localparam logic [23:0] BusyLimit = 24'(BUSY_MAX_SAMPLES);

  sd_rx_state_e state_q, state_d;
  logic         is_long_q, is_long_d;
  logic         is_r1b_q, is_r1b_d;
  logic [39:0]  shift_q, shift_d;
  logic [5:0]   bit_cnt_q, bit_cnt_d;
  logic [23:0]  sample_cnt_q, sample_cnt_d;
  logic         tmo_flag_q, tmo_flag_d;

  logic [5:0]   bit_cnt_inc;
  logic [23:0]  sample_cnt_inc;
  logic         ncr_hit;
  logic         busy_hit;

  // The sample counter saturates at its limit, so the increment cannot wrap
  // for any legal limit; the hit flags include the sample being taken now.
  assign bit_cnt_inc    = bit_cnt_q + 6'd1;
  assign sample_cnt_inc = sample_cnt_q + 24'd1;
  assign ncr_hit        = (sample_cnt_inc >= NcrLimit);
  assign busy_hit       = (sample_cnt_inc >= BusyLimit);

  // Next-state logic for the FSM, shift register and counters
  always_comb begin
    state_d      = state_q;
    is_long_d    = is_long_q;
    is_r1b_d     = is_r1b_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    sample_cnt_d = sample_cnt_q;
    tmo_flag_d   = tmo_flag_q;

    unique case (state_q)
      SdIdle: begin
        // sample_en is ignored here, so a coinciding sample is never used
        if (receive) begin
          is_long_d    = (response_type == SdRespR3R7);
          is_r1b_d     = (response_type == SdRespR1b);
          shift_d      = '0;
          bit_cnt_d    = '0;
          sample_cnt_d = '0;
          tmo_flag_d   = 1'b0;
          state_d      = SdWaitStart;
        end
      end

      SdWaitStart: begin
        if (sample_en) begin
          if (!miso) begin
            // Start bit doubles as R1 bit 7, so it is kept in the response
            shift_d   = {shift_q[38:0], 1'b0};
            bit_cnt_d = 6'd1;
            state_d   = SdShift;
          end else if (ncr_hit) begin
            sample_cnt_d = NcrLimit;
            shift_d      = SdTimeoutResp;
            tmo_flag_d   = 1'b1;
            state_d      = SdDone;
          end else begin
            sample_cnt_d = sample_cnt_inc;
          end
        end
      end

      SdShift: begin
        if (sample_en) begin
          shift_d   = {shift_q[38:0], miso};
          bit_cnt_d = bit_cnt_inc;
          if (bit_cnt_inc == sd_resp_len(is_long_q)) begin
            if (is_r1b_q) begin
              // Busy phase gets its own fresh sample budget
              sample_cnt_d = '0;
              state_d      = SdWaitBusy;
            end else begin
              state_d = SdDone;
            end
          end
        end
      end

      SdWaitBusy: begin
        // Runs whatever the R1 error bits say; R1 stays in the response
        if (sample_en) begin
          if (miso) begin
            state_d = SdDone;
          end else if (busy_hit) begin
            sample_cnt_d = BusyLimit;
            tmo_flag_d   = 1'b1;
            state_d      = SdDone;
          end else begin
            sample_cnt_d = sample_cnt_inc;
          end
        end
      end

      SdDone: begin
        state_d = SdIdle;
      end

      default: begin
        state_d = SdIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= SdIdle;
      is_long_q    <= 1'b0;
      is_r1b_q     <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      sample_cnt_q <= '0;
      tmo_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_long_q    <= is_long_d;
      is_r1b_q     <= is_r1b_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      tmo_flag_q   <= tmo_flag_d;
    end
  end

  // Outputs decode straight from registers, so reset clears them at once
  assign response       = shift_q;
  assign response_valid = (state_q == SdDone);
  assign timeout        = (state_q == SdDone) && tmo_flag_q;
  assign busy           = (state_q != SdIdle);

endmodule

// File: tb/tb_sd_resp_receiver.sv
// Directed bench for sd_resp_receiver: R1, R7, N_CR timeout, R1b busy wait,
// ignored re-arm, receive/sample collision and asynchronous reset.
module tb_sd_resp_receiver;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        miso = 1'b1;
  logic        sample_en = 1'b0;
  logic        receive = 1'b0;
  logic [1:0]  response_type = 2'd0;
  logic [39:0] response;
  logic        response_valid;
  logic        timeout;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  sd_resp_receiver #(
    .NCR_MAX_SAMPLES (80),
    .BUSY_MAX_SAMPLES(500000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .miso          (miso),
    .sample_en     (sample_en),
    .receive       (receive),
    .response_type (response_type),
    .response      (response),
    .response_valid(response_valid),
    .timeout       (timeout),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // Advance one clock; outputs are then sampled 1 ns after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    miso      = b;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    miso      = 1'b1;
  endtask

  task automatic arm(input logic [1:0] t);
    response_type = t;
    receive       = 1'b1;
    tick();
    receive       = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arm_busy got=%b exp=1", busy); end
    n_cmp++; if (response !== 40'h0) begin n_fail++; $display("FAIL arm_clear got=%h exp=0", response); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_cmp++; if (response !== 40'h0) begin n_fail++; $display("FAIL rst_response got=%h exp=0", response); end
    n_cmp++; if (response_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", response_valid); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    reset = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
    $display("txn reset busy=%b valid=%b", busy, response_valid);
  endtask

  // R1 0x01 after 3 idle samples, with gap cycles between samples
  task automatic test_r1();
    logic [7:0] v;
    v = 8'h01;
    arm(2'd0);
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1);
      tick();
    end
    for (int i = 7; i >= 1; i--) begin
      send_bit(v[i]);
      if (i % 2 == 0) tick();
    end
    n_cmp++; if (response_valid !== 1'b0) begin n_fail++; $display("FAIL r1_early got=%b exp=0", response_valid); end
    send_bit(v[0]);
    n_cmp++; if (response_valid !== 1'b1) begin n_fail++; $display("FAIL r1_valid got=%b exp=1", response_valid); end
    n_cmp++; if (response !== 40'h01) begin n_fail++; $display("FAIL r1_response got=%h exp=01", response); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL r1_timeout got=%b exp=0", timeout); end
    tick();
    n_cmp++; if (response_valid !== 1'b0) begin n_fail++; $display("FAIL r1_strobe_len got=%b exp=0", response_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL r1_busy_fall got=%b exp=0", busy); end
    n_cmp++; if (response !== 40'h01) begin n_fail++; $display("FAIL r1_hold got=%h exp=01", response); end
    $display("txn r1 response=%h", response);
  endtask

  task automatic test_r7();
    logic [39:0] v;
    v = 40'h01_0000_01AA;
    arm(2'd2);
    send_bit(1'b1);
    for (int i = 39; i >= 1; i--) send_bit(v[i]);
    n_cmp++; if (response_valid !== 1'b0) begin n_fail++; $display("FAIL r7_early got=%b exp=0", response_valid); end
    send_bit(v[0]);
    n_cmp++; if (response_valid !== 1'b1) begin n_fail++; $display("FAIL r7_valid got=%b exp=1", response_valid); end
    n_cmp++; if (response !== 40'h01_0000_01AA) begin n_fail++; $display("FAIL r7_response got=%h exp=01000001aa", response); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL r7_timeout got=%b exp=0", timeout); end
    tick();
    $display("txn r7 response=%h", response);
  endtask

  task automatic test_ncr_timeout();
    arm(2'd0);
    for (int i = 0; i < 79; i++) send_bit(1'b1);
    n_cmp++; if (response_valid !== 1'b0) begin n_fail++; $display("FAIL ncr_early got=%b exp=0", response_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ncr_busy got=%b exp=1", busy); end
    send_bit(1'b1);
    n_cmp++; if (response_valid !== 1'b1) begin n_fail++; $display("FAIL ncr_valid got=%b exp=1", response_valid); end
    n_cmp++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL ncr_timeout got=%b exp=1", timeout); end
    n_cmp++; if (response !== 40'hFF_FFFF_FFFF) begin n_fail++; $display("FAIL ncr_response got=%h exp=ffffffffff", response); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ncr_busy_fall got=%b exp=0", busy); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL ncr_timeout_fall got=%b exp=0", timeout); end
    $display("txn ncr_timeout response=%h", response);
  endtask

  task automatic test_r1b();
    arm(2'd1);
    for (int i = 0; i < 8; i++) send_bit(1'b0);
    n_cmp++; if (response_valid !== 1'b0) begin n_fail++; $display("FAIL r1b_no_valid_at_r1 got=%b exp=0", response_valid); end
    for (int i = 0; i < 20; i++) send_bit(1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL r1b_busy got=%b exp=1", busy); end
    n_cmp++; if (response_valid !== 1'b0) begin n_fail++; $display("FAIL r1b_early got=%b exp=0", response_valid); end
    send_bit(1'b1);
    n_cmp++; if (response_valid !== 1'b1) begin n_fail++; $display("FAIL r1b_valid got=%b exp=1", response_valid); end
    n_cmp++; if (response !== 40'h0) begin n_fail++; $display("FAIL r1b_response got=%h exp=0", response); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL r1b_timeout got=%b exp=0", timeout); end
    tick();
    $display("txn r1b response=%h", response);
  endtask

  // A second receive (asking for a 40-bit type) mid-response is ignored
  task automatic test_receive_while_busy();
    logic [7:0] v;
    v = 8'h3C;
    arm(2'd0);
    send_bit(1'b1);
    send_bit(v[7]);
    send_bit(v[6]);
    response_type = 2'd2;
    receive       = 1'b1;
    tick();
    receive       = 1'b0;
    n_cmp++; if (response !== 40'h0) begin n_fail++; $display("FAIL rwb_partial got=%h exp=0", response); end
    for (int i = 5; i >= 0; i--) send_bit(v[i]);
    n_cmp++; if (response_valid !== 1'b1) begin n_fail++; $display("FAIL rwb_valid got=%b exp=1", response_valid); end
    n_cmp++; if (response !== 40'h3C) begin n_fail++; $display("FAIL rwb_response got=%h exp=3c", response); end
    tick();
    $display("txn receive_while_busy response=%h", response);
  endtask

  // miso=0 sampled together with receive must not count as the start bit
  task automatic test_receive_with_sample();
    logic [7:0] v;
    v = 8'h5A;
    response_type = 2'd0;
    receive       = 1'b1;
    sample_en     = 1'b1;
    miso          = 1'b0;
    tick();
    receive       = 1'b0;
    sample_en     = 1'b0;
    miso          = 1'b1;
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    n_cmp++; if (response_valid !== 1'b0) begin n_fail++; $display("FAIL rws_early got=%b exp=0", response_valid); end
    send_bit(v[0]);
    n_cmp++; if (response_valid !== 1'b1) begin n_fail++; $display("FAIL rws_valid got=%b exp=1", response_valid); end
    n_cmp++; if (response !== 40'h5A) begin n_fail++; $display("FAIL rws_response got=%h exp=5a", response); end
    tick();
    $display("txn receive_with_sample response=%h", response);
  endtask

  task automatic test_async_reset();
    logic [7:0] v;
    arm(2'd0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    n_cmp++; if (response !== 40'h07) begin n_fail++; $display("FAIL ar_partial got=%h exp=07", response); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy got=%b exp=0", busy); end
    n_cmp++; if (response_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got=%b exp=0", response_valid); end
    n_cmp++; if (response !== 40'h0) begin n_fail++; $display("FAIL ar_response got=%h exp=0", response); end
    tick();
    reset = 1'b0;
    tick();
    v = 8'h05;
    arm(2'd0);
    send_bit(1'b1);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    n_cmp++; if (response_valid !== 1'b1) begin n_fail++; $display("FAIL ar_fresh_valid got=%b exp=1", response_valid); end
    n_cmp++; if (response !== 40'h05) begin n_fail++; $display("FAIL ar_fresh_response got=%h exp=05", response); end
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL ar_fresh_timeout got=%b exp=0", timeout); end
    tick();
    $display("txn async_reset response=%h", response);
  endtask

  initial begin
    test_reset();
    test_r1();
    test_r7();
    test_ncr_timeout();
    test_r1b();
    test_receive_while_busy();
    test_receive_with_sample();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sd_resp_receiver.md
# sd_resp_receiver

SPI-mode SD card response receiver. Once armed by the SD controller FSM after a command has been shifted out, it hunts MISO for the response start bit within the N_CR window and shifts in an R1, R1b or R3/R7 response MSB-first. It then presents the response with a one-cycle valid strobe or flags a timeout. It sits between the SPI pins and the SD init/read FSM, alongside the command sender.

## Interface
Parameters:
- NCR_MAX_SAMPLES, 80: MISO samples allowed before the start bit; exceeding it is a timeout.
- BUSY_MAX_SAMPLES, 500000: R1b busy samples allowed before a timeout; limit is 24 bits.

Ports:
- clock  in  1  system clock, the only clock.
- reset  in  1  asynchronous, active-high.
- miso  in  1  card data out, already synchronised.
- sample_en  in  1  one-cycle pulse at each SCK sampling edge (SCK rise, mode 0), from the SCK generator.
- receive  in  1  one-cycle arm request; accepted only in Idle.
- response_type  in  2  sampled with receive: 0 = R1, 1 = R1b, 2 = R3/R7 (40 bit), 3 = treated as R1.
- response  out  40  R1 in [7:0] for R1/R1b; for 40-bit types, R1 in [39:32] and payload in [31:0]. Upper bits are zero for short types.
- response_valid  out  1  one-cycle completion strobe.
- timeout  out  1  qualifies response_valid; completion was a timeout.
- busy  out  1  high whenever the FSM is not in Idle.

## Operation
- Reset values: state Idle; response 0, response_valid 0, timeout 0, busy 0; all counters 0.
- Idle:
  - On receive, latch the type, clear both counters and go to WaitStart.
  - A receive in any other state is ignored.
- WaitStart: on each sample_en:
  - miso = 0: this is the start bit, which is also R1 bit 7. Shift it in, set bit count = 1, go to Shift.
  - miso = 1 and the sample count reaches NCR_MAX_SAMPLES: go to Done with the timeout flag set.
  - Otherwise increment the sample count.
- Shift:
  - On each sample_en, shift miso into the LSB and increment the bit count.
  - At 8 bits for R1/R1b, or 40 bits for R3/R7, go to Done, or to WaitBusy for R1b.
- WaitBusy:
  - On each sample_en with miso = 1, the card is released: go to Done.
  - Otherwise count samples; at BUSY_MAX_SAMPLES go to Done with timeout.
  - The wait runs regardless of the R1 error bits.
- Done (one cycle):
  - Drive response_valid = 1, and timeout = 1 if the timeout flag is set, then return to Idle.
  - On an N_CR timeout, response = 40'hFF_FFFF_FFFF.
  - On a busy timeout, response holds the received R1.
- response holds its value until the next accepted receive, which clears it to 0 in the acceptance cycle.
- Reset mid-operation: immediate return to Idle and all outputs to their reset values. No partial response is reported.

## Timing
- Counters:
  - The sample counter counts sample_en events only, never clock cycles.
  - The bit counter is 6 bits and compares against 8 or 40.
  - The sample counter is 24 bits and saturates at its limit.
- A receive accepted in cycle T raises busy at T+1.
- A sample_en coinciding with receive in the same cycle is not used; the first sample is the next sample_en.
- The last data sample (or busy release) in cycle S produces response_valid high in S+1; busy falls in S+2, when the FSM is back in Idle.
- With back-to-back sample_en, R1 latency from the start bit is 8 samples plus 1 cycle; R3/R7 is 40 samples plus 1 cycle.
- sample_en is ignored in Idle and Done.
- The earliest re-arm is a receive in the cycle after response_valid.

## Structure
- Shared package sd_pkg holds:
  - the response_type encodings (SdRespR1, SdRespR1b, SdRespR3R7);
  - the response lengths (8, 40);
  - the FSM state encoding (Idle, WaitStart, Shift, WaitBusy, Done);
  - the timeout response value.
- No sub-module: one FSM, one 40-bit shift register and two counters, all inline.

## Test plan
- R1: arm type 0; MISO high for 3 samples, then 0x01 -> response = 0x01, response_valid one cycle after the 8th data sample, timeout = 0.
- R7: arm type 2; after 1 idle sample, bytes 01 00 00 01 AA -> response = 40'h01_0000_01AA, 40 samples consumed.
- N_CR timeout: arm type 0, hold MISO high -> on the 80th sample, response_valid with timeout = 1 and response = 40'hFF_FFFF_FFFF.
- R1b: arm type 1; R1 = 0x00 followed by 20 zero samples, then MISO high -> response_valid one cycle after the first high sample, response = 0x00, timeout = 0.
- Corner cases:
  - receive while busy is ignored.
  - receive coinciding with sample_en skips that sample.
  - async reset asserted mid-Shift -> busy, response_valid and response are 0 immediately; a fresh R1 0x05 then received correctly.
